// File: rtl/sdiv_seq_pkg.sv
// Shared types for the sdiv operand sequencer: FSM states, result codes, pre-screen bundle.
// Magnitude helpers return unsigned widths wide enough for the most negative input.
package sdiv_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        RESP      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK   = 2'b00,
        ERR_DIV0 = 2'b01,
        ERR_OVF  = 2'b10,
        ERR_TMO  = 2'b11
    } err_t;

    typedef struct packed {
        logic       div0;
        logic       ovf;
        logic [7:0] mag_dividend;
        logic [3:0] mag_divisor;
    } screen_t;

    // -128 maps to 8'h80, read back as unsigned 128
    function automatic logic [7:0] mag8(input logic [7:0] v);
        return v[7] ? 8'(-v) : v;
    endfunction

    function automatic logic [3:0] mag4(input logic [3:0] v);
        return v[3] ? 4'(-v) : v;
    endfunction

endpackage

// File: rtl/sdiv_seq_if.sv
// Operand/result streams plus the sequencer-to-divider handshake.
// master = sequencer side, slave = producer/consumer/divider side.
interface sdiv_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_dividend;
    logic [3:0] in_divisor;
    logic       div_start;
    logic [7:0] div_word1;
    logic [3:0] div_word2;
    logic       div_ready;
    logic [3:0] div_quotient;
    logic [3:0] div_remainder;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_quotient;
    logic [3:0] out_remainder;
    logic [1:0] out_err;
    logic       busy;

    modport master (
        input  in_valid, in_dividend, in_divisor,
        output in_ready,
        output div_start, div_word1, div_word2,
        input  div_ready, div_quotient, div_remainder,
        output out_valid, out_quotient, out_remainder, out_err,
        input  out_ready,
        output busy
    );

    modport slave (
        output in_valid, in_dividend, in_divisor,
        input  in_ready,
        input  div_start, div_word1, div_word2,
        output div_ready, div_quotient, div_remainder,
        input  out_valid, out_quotient, out_remainder, out_err,
        output out_ready,
        input  busy
    );
endinterface

// File: rtl/sdiv_prescreen.sv
// Combinational operand screen: flags divide-by-zero and any quotient that cannot fit 4 signed bits.
// Overflow is conservative (|a| >= 8|b|), so an exact -8 quotient is rejected too.
module sdiv_prescreen
    import sdiv_seq_pkg::*;
(
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output screen_t    screen
);

    always_comb begin
        screen              = '0;
        screen.mag_dividend = mag8(dividend);
        screen.mag_divisor  = mag4(divisor);
        screen.div0         = (divisor == 4'd0);
        screen.ovf          = !screen.div0 &&
                              (screen.mag_dividend >= {1'b0, screen.mag_divisor, 3'b000});
    end

endmodule

// File: rtl/sdiv_seq.sv
// Sequencer wrapping the 8/4 signed divider in valid/ready streams; ok result 7 cycles after accept, screened error 1 cycle.
// One op in flight; in_ready only in IDLE, result held in RESP until out_ready.
module sdiv_seq
    import sdiv_seq_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    sdiv_seq_if.master io
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [7:0]         word1, word1_nxt;
    logic [3:0]         word2, word2_nxt;
    logic [3:0]         quo, quo_nxt;
    logic [3:0]         rem, rem_nxt;
    err_t               err, err_nxt;
    screen_t            screen;

    sdiv_prescreen u_prescreen (
        .dividend (io.in_dividend),
        .divisor  (io.in_divisor),
        .screen   (screen)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        word1_nxt = word1;
        word2_nxt = word2;
        quo_nxt   = quo;
        rem_nxt   = rem;
        err_nxt   = err;
        case (state)
            IDLE: begin
                if (io.in_valid) begin
                    word1_nxt = io.in_dividend;
                    word2_nxt = io.in_divisor;
                    quo_nxt   = 4'd0;
                    rem_nxt   = 4'd0;
                    if (screen.div0) begin
                        err_nxt   = ERR_DIV0;
                        state_nxt = RESP;
                    end else if (screen.ovf) begin
                        err_nxt   = ERR_OVF;
                        state_nxt = RESP;
                    end else begin
                        err_nxt   = ERR_OK;
                        state_nxt = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: begin
                cnt_nxt = cnt + 1'b1;
                // Timeout wins here so WAIT_HIGH is never entered with a spent budget
                if (cnt_nxt == CNT_W'(TIMEOUT)) begin
                    err_nxt   = ERR_TMO;
                    state_nxt = RESP;
                end else if (!io.div_ready) begin
                    state_nxt = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                cnt_nxt = cnt + 1'b1;
                if (io.div_ready) begin
                    quo_nxt   = io.div_quotient;
                    rem_nxt   = io.div_remainder;
                    err_nxt   = ERR_OK;
                    state_nxt = RESP;
                end else if (cnt_nxt == CNT_W'(TIMEOUT)) begin
                    err_nxt   = ERR_TMO;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (io.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            word1 <= '0;
            word2 <= '0;
            quo   <= '0;
            rem   <= '0;
            err   <= ERR_OK;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            word1 <= word1_nxt;
            word2 <= word2_nxt;
            quo   <= quo_nxt;
            rem   <= rem_nxt;
            err   <= err_nxt;
        end
    end

    assign io.in_ready      = (state == IDLE);
    assign io.div_start     = (state == LAUNCH);
    assign io.out_valid     = (state == RESP);
    assign io.busy          = (state != IDLE);
    assign io.div_word1     = word1;
    assign io.div_word2     = word2;
    assign io.out_quotient  = quo;
    assign io.out_remainder = rem;
    assign io.out_err       = err;

endmodule

// File: doc/sdiv_seq.md
Name: sdiv_seq

Overview:
- Operand sequencer that sits directly upstream of the 8-by-4 signed sequential divider (sdiv) and wraps it in valid/ready streams.
- Accepts one dividend/divisor pair, pre-screens it for divide-by-zero and quotient overflow, and launches the divider with a one-cycle start.
- Detects completion from the divider's ready line, with a hang timeout.
- Holds quotient/remainder plus an error code until the consumer takes them.

Parameters:
- TIMEOUT, 15: maximum cycles spent in WAIT_LOW+WAIT_HIGH before the op is aborted with a timeout error.
- CNT_W, 4: timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept an operand pair
- in_dividend  in  8  two's-complement dividend
- in_divisor  in  4  two's-complement divisor
- div_start  out  1  one-cycle start pulse to the divider
- div_word1  out  8  registered dividend to the divider
- div_word2  out  4  registered divisor to the divider
- div_ready  in  1  divider idle/done indication (high when idle)
- div_quotient  in  4  divider quotient
- div_remainder  in  4  divider remainder
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_quotient  out  4  result quotient
- out_remainder  out  4  result remainder
- out_err  out  2  result status: 00 ok, 01 divide-by-zero, 10 overflow, 11 timeout
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-low. While reset=0 at a rising edge:
  - state goes to IDLE.
  - out_valid, div_start, busy, out_quotient, out_remainder, out_err, div_word1, div_word2 and the timeout counter all go to 0.
  - Reset mid-operation abandons the op silently. No result is produced.
- Outputs:
  - in_ready = (state==IDLE), combinational.
  - div_start = (state==LAUNCH), combinational.
  - out_valid = (state==RESP), combinational.
- IDLE:
  - On in_valid, capture the operands into div_word1/div_word2.
  - Pre-screen the operands:
    - Divisor zero: go to RESP with err=01, q=0, r=0.
    - Overflow when |dividend| >= 8*|divisor|, where magnitudes are unsigned and |-128|=128. Go to RESP with err=10, q=0, r=0. This is deliberately conservative: an exact quotient of -8 is also flagged.
    - Otherwise go to LAUNCH.
- LAUNCH: lasts exactly one cycle with div_start=1. Clear the timeout counter. Go to WAIT_LOW.
- WAIT_LOW:
  - The counter increments each cycle.
  - div_ready=0 goes to WAIT_HIGH.
  - Counter reaching TIMEOUT goes to RESP with err=11.
- WAIT_HIGH:
  - The counter increments each cycle.
  - div_ready=1 registers div_quotient/div_remainder into out_quotient/out_remainder with err=00, then goes to RESP.
  - Counter reaching TIMEOUT goes to RESP with err=11, q=0, r=0.
- RESP: hold all result outputs stable. When out_ready=1, go to IDLE.
- Latency:
  - Error-free op accepted at edge N: div_start during cycle N+1, divider busy cycles N+2..N+5, capture at edge N+6, out_valid from cycle N+7.
  - Pre-screened error: out_valid from cycle N+1.
- Throughput: one op per 8 cycles minimum. in_ready is low in RESP, so a new op is accepted no earlier than the cycle after the output handshake.
- Operand stability: div_word1/div_word2 are held from capture until the next accept, so the divider always loads stable operands.
- Result passthrough: signs are not modified. Quotient and remainder semantics are the divider's.

Decomposition:
- Shared package:
  - State encoding: IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, RESP (3 bits).
  - out_err codes: ERR_OK, ERR_DIV0, ERR_OVF, ERR_TMO.
- One natural sub-module: sdiv_prescreen. It is combinational, takes the operands, and returns div0, ovf and the magnitudes.
- FSM and registers live in sdiv_seq.

Test Plan:
- Benches use a behavioural divider model that holds div_ready low for exactly 4 cycles after start.
- Normal op: dividend 50, divisor 7, out_ready=1 -> single div_start pulse 1 cycle after accept; out_valid 7 cycles after accept; q=7, r=1, err=00; in_ready high the next cycle.
- Divide-by-zero: dividend 20, divisor 0 -> no div_start; out_valid the next cycle; err=01, q=0, r=0.
- Overflow: dividend 100, divisor 7 (100>=56) -> no div_start; err=10. Dividend -128, divisor -8 (128>=64) -> err=10.
- Backpressure: out_ready held 0 for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout; a new in_valid is not accepted until one cycle after out_ready=1.
- Timeout: divider model never lowers div_ready -> err=11 after TIMEOUT cycles. Divider model stuck low -> err=11, q=r=0.
- Reset mid-op: reset=0 in cycle N+3 of an op -> next edge IDLE, out_valid=0, in_ready=1, busy=0, and no result is emitted.
